// File: rtl/t09_sound_seq.sv
`default_nettype none
// ============================================================================
//  Module   : t09_sound_seq
//  Brief    : Prioritised game-event sound sequencer. Latches rising edges on
//             NUM_EVENTS event lines into a pending set and plays one
//             fixed-length square-wave burst per event, lowest index first.
//             Owns the sound-on / mute mode toggle.
//
//  Ports    : clk        system clock
//             rst        synchronous active-high reset
//             event_i    level event lines, rising edge requests a tone
//             button     mode toggle, rising edge flips mode_o
//             mode_o     1 = sound enabled, 0 = muted
//             playSound  high while a burst is playing
//             sound_o    square-wave speaker drive
//             active_id  index of the event currently or last played
//             pending_o  pending request set
//
//  Options  : SOUND_PREEMPT_EN - when defined, a pending request with a lower
//             index than the one playing aborts the current burst and
//             restarts PLAY directly with the new index.
//
//  Revision : 1.0 - initial release
// ============================================================================
module t09_sound_seq #(
    parameter int NUM_EVENTS = 4,
    parameter int DUR_CYCLES = 20000,
    parameter int GAP_CYCLES = 2000,
    parameter int HALF_BASE  = 50
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUM_EVENTS-1:0]                                event_i,
    input  logic                                                 button,
    output logic                                                 mode_o,
    output logic                                                 playSound,
    output logic                                                 sound_o,
    output logic [((NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1)-1:0] active_id,
    output logic [NUM_EVENTS-1:0]                                pending_o
);

    localparam int ID_W  = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam int DUR_W = $clog2(DUR_CYCLES + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int HP_W  = $clog2(HALF_BASE * NUM_EVENTS + 1);

    localparam logic [DUR_W-1:0] c_dur_last = DUR_W'(DUR_CYCLES - 1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               c_has_gap  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_EVENTS-1:0] r_ev_prev;
    logic                  r_btn_prev;
    logic [DUR_W-1:0]      r_dur_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [HP_W-1:0]       r_hp_cnt;

    logic [NUM_EVENTS-1:0] w_ev_rise;
    logic                  w_btn_rise;
    logic                  w_pend_any;
    logic [ID_W-1:0]       w_sel;
    logic [NUM_EVENTS-1:0] w_sel_oh;
    logic [HP_W-1:0]       w_half_last;
    logic                  w_preempt;
    logic                  w_enter_play;

    assign w_ev_rise  = event_i & ~r_ev_prev;
    assign w_btn_rise = button & ~r_btn_prev;
    assign w_pend_any = |pending_o;

    // Lowest set pending index wins; scanning downwards lets the last hit
    // (the lowest index) overwrite any higher one.
    always_comb begin
        w_sel    = '0;
        w_sel_oh = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (pending_o[i]) begin
                w_sel       = ID_W'(i);
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    // Terminal count of the half-period counter for the playing index:
    // HALF_BASE*(active_id+1) cycles per level.
    always_comb begin
        w_half_last = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (active_id == ID_W'(i)) begin
                w_half_last = HP_W'(HALF_BASE * (i + 1) - 1);
            end
        end
    end

`ifdef SOUND_PREEMPT_EN
    // Any pending request strictly more urgent than the playing one.
    always_comb begin
        w_preempt = 1'b0;
        if (r_state == S_PLAY) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (pending_o[i] && (ID_W'(i) < active_id)) begin
                    w_preempt = 1'b1;
                end
            end
        end
    end
`else
    assign w_preempt = 1'b0;
`endif

    // PLAY is entered from IDLE with something pending, or restarted in
    // place by a pre-emption. Both paths share the same reload sequence.
    assign w_enter_play = ((r_state == S_IDLE) && w_pend_any) || w_preempt;

    always_ff @(posedge clk) begin
        if (rst) begin
            // History takes the live inputs so lines already high at reset
            // do not register as rising edges afterwards.
            r_ev_prev  <= event_i;
            r_btn_prev <= button;
            mode_o     <= 1'b1;
            playSound  <= 1'b0;
            sound_o    <= 1'b0;
            active_id  <= '0;
            pending_o  <= '0;
            r_state    <= S_IDLE;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_hp_cnt   <= '0;
        end else begin
            r_ev_prev  <= event_i;
            r_btn_prev <= button;

            if (w_btn_rise) begin
                // A mode flip in either direction leaves the sequencer idle
                // with nothing queued; it also wins over a burst ending on
                // the same edge and swallows event rises of this cycle.
                mode_o    <= ~mode_o;
                pending_o <= '0;
                r_state   <= S_IDLE;
                playSound <= 1'b0;
                sound_o   <= 1'b0;
                r_dur_cnt <= '0;
                r_gap_cnt <= '0;
                r_hp_cnt  <= '0;
            end else if (mode_o) begin
                pending_o <= pending_o | w_ev_rise;

                if (w_enter_play) begin
                    // A rise on the selected line this very cycle survives
                    // the clear, so that event is queued to play again.
                    pending_o <= (pending_o & ~w_sel_oh) | w_ev_rise;
                    active_id <= w_sel;
                    r_state   <= S_PLAY;
                    playSound <= 1'b1;
                    sound_o   <= 1'b0;
                    r_dur_cnt <= '0;
                    r_hp_cnt  <= '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            playSound <= 1'b0;
                            sound_o   <= 1'b0;
                        end

                        S_PLAY: begin
                            if (r_dur_cnt == c_dur_last) begin
                                playSound <= 1'b0;
                                sound_o   <= 1'b0;
                                r_dur_cnt <= '0;
                                r_hp_cnt  <= '0;
                                r_gap_cnt <= '0;
                                if (c_has_gap) begin
                                    r_state <= S_GAP;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_dur_cnt <= r_dur_cnt + DUR_W'(1);
                                if (r_hp_cnt == w_half_last) begin
                                    r_hp_cnt <= '0;
                                    sound_o  <= ~sound_o;
                                end else begin
                                    r_hp_cnt <= r_hp_cnt + HP_W'(1);
                                end
                            end
                        end

                        S_GAP: begin
                            playSound <= 1'b0;
                            sound_o   <= 1'b0;
                            if (r_gap_cnt == c_gap_last) begin
                                r_gap_cnt <= '0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                            end
                        end

                        default: begin
                            r_state   <= S_IDLE;
                            playSound <= 1'b0;
                            sound_o   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t09_sound_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t09_sound_seq
//  Brief    : Self-checking bench for t09_sound_seq. Instance A runs with
//             DUR=8, GAP=2, HALF_BASE=2; instance B with DUR=1, GAP=0.
//             Expected burst indices are queued when events are driven and
//             compared when a burst starts on instance A.
//  Options  : honours SOUND_PREEMPT_EN for the pre-emption expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_t09_sound_seq;

    localparam int NE  = 4;
    localparam int DUR = 8;
    localparam int GAP = 2;
    localparam int HB  = 2;

    logic          clk;
    logic          rst;
    logic [NE-1:0] ev;
    logic          button;
    logic          mode, ps, snd;
    logic [1:0]    aid;
    logic [NE-1:0] pend;

    logic [NE-1:0] ev_b;
    logic          btn_b;
    logic          mode_b, ps_b, snd_b;
    logic [1:0]    aid_b;
    logic [NE-1:0] pend_b;

    int checks   = 0;
    int failures = 0;

    logic [1:0] q_exp[$];
    bit         in_burst = 0;
    bit         abort_ok = 0;
    int         blen     = 0;
    logic [1:0] bid      = 2'd0;

    t09_sound_seq #(
        .NUM_EVENTS(NE), .DUR_CYCLES(DUR), .GAP_CYCLES(GAP), .HALF_BASE(HB)
    ) u_dut_a (
        .clk(clk), .rst(rst), .event_i(ev), .button(button),
        .mode_o(mode), .playSound(ps), .sound_o(snd),
        .active_id(aid), .pending_o(pend)
    );

    t09_sound_seq #(
        .NUM_EVENTS(NE), .DUR_CYCLES(1), .GAP_CYCLES(0), .HALF_BASE(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .event_i(ev_b), .button(btn_b),
        .mode_o(mode_b), .playSound(ps_b), .sound_o(snd_b),
        .active_id(aid_b), .pending_o(pend_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Burst monitor for instance A: pops the expected index on each burst
    // start (including an in-place index change), checks the tone against
    // a half-period model and the burst length at its end.
    always @(negedge clk) begin
        if (rst) begin
            in_burst = 0;
            abort_ok = 0;
        end else if (ps === 1'b1) begin
            if (!in_burst || aid !== bid) begin
                in_burst = 1;
                blen     = 0;
                bid      = aid;
                checks++;
                if (q_exp.size() == 0) begin
                    failures++;
                    $display("FAIL burst_id: unexpected burst id=%0d, expected none", aid);
                end else begin
                    logic [1:0] e;
                    e = q_exp.pop_front();
                    if (aid !== e) begin
                        failures++;
                        $display("FAIL burst_id: got %0d expected %0d", aid, e);
                    end
                end
            end
            begin
                int  hp;
                logic es;
                hp = HB * (int'(bid) + 1);
                es = ((blen / hp) % 2) == 1;
                checks++;
                if (snd !== es) begin
                    failures++;
                    $display("FAIL tone: id=%0d cycle=%0d sound_o=%b expected %b", bid, blen, snd, es);
                end
            end
            blen++;
        end else begin
            if (in_burst) begin
                if (!abort_ok) begin
                    checks++;
                    if (blen != DUR) begin
                        failures++;
                        $display("FAIL burst_len: id=%0d got %0d expected %0d", bid, blen, DUR);
                    end
                end
                abort_ok = 0;
                in_burst = 0;
            end
            checks++;
            if (snd !== 1'b0) begin
                failures++;
                $display("FAIL silent: sound_o=%b expected 0 while playSound=0", snd);
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; ev = '0; button = 1'b0; ev_b = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mode !== 1'b1) begin failures++; $display("FAIL reset_mode: got %b expected 1", mode); end
        checks++;
        if ({ps, snd} !== 2'b00) begin failures++; $display("FAIL reset_out: ps/snd=%b expected 00", {ps, snd}); end
        checks++;
        if ({aid, pend} !== 6'd0) begin failures++; $display("FAIL reset_state: aid=%0d pend=%b expected 0", aid, pend); end
        checks++;
        if ({mode_b, ps_b, pend_b} !== 6'b100000) begin failures++; $display("FAIL reset_b: mode=%b ps=%b pend=%b expected 1,0,0000", mode_b, ps_b, pend_b); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q_exp.size() != 0 || ps === 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            failures++;
            $display("FAIL %s_timeout: queue=%0d ps=%b after %0d cycles, expected drained", name, q_exp.size(), ps, t);
        end
    endtask

    task automatic test_trigger();
        @(negedge clk);
        ev[2] = 1'b1; q_exp.push_back(2'd2);
        @(negedge clk);
        checks++;
        if (pend !== 4'b0100 || ps !== 1'b0) begin failures++; $display("FAIL trig_pend: pend=%b ps=%b expected 0100,0", pend, ps); end
        @(negedge clk);
        checks++;
        if (ps !== 1'b1 || aid !== 2'd2) begin failures++; $display("FAIL trig_start: ps=%b aid=%0d expected 1,2", ps, aid); end
        checks++;
        if (pend !== 4'b0000) begin failures++; $display("FAIL trig_clear: pend=%b expected 0000", pend); end
        ev[2] = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (snd !== 1'b0) begin failures++; $display("FAIL trig_tone0: sound_o=%b expected 0", snd); end
        @(negedge clk);
        checks++;
        if (snd !== 1'b1) begin failures++; $display("FAIL trig_tone1: sound_o=%b expected 1", snd); end
        drain("trig");
    endtask

    task automatic test_priority();
        int t, lo;
        @(negedge clk);
        ev[3] = 1'b1; ev[1] = 1'b1;
        q_exp.push_back(2'd1); q_exp.push_back(2'd3);
        @(negedge clk);
        checks++;
        if (pend !== 4'b1010) begin failures++; $display("FAIL prio_pend: got %b expected 1010", pend); end
        @(negedge clk);
        checks++;
        if (ps !== 1'b1 || aid !== 2'd1 || pend !== 4'b1000) begin failures++; $display("FAIL prio_first: ps=%b aid=%0d pend=%b expected 1,1,1000", ps, aid, pend); end
        ev = '0;
        t = 0;
        while (ps === 1'b1 && t < 50) begin @(negedge clk); t++; end
        lo = 0;
        while (ps !== 1'b1 && lo < 50) begin @(negedge clk); lo++; end
        checks++;
        if (lo != GAP + 1) begin failures++; $display("FAIL prio_gap: low cycles %0d expected %0d", lo, GAP + 1); end
        checks++;
        if (aid !== 2'd3 || pend !== 4'b0000) begin failures++; $display("FAIL prio_second: aid=%0d pend=%b expected 3,0000", aid, pend); end
        drain("prio");
    endtask

    task automatic test_mute();
        @(negedge clk);
        ev[3] = 1'b1; q_exp.push_back(2'd3);
        @(negedge clk);
        @(negedge clk);
        ev[3] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ps !== 1'b1) begin failures++; $display("FAIL mute_pre: ps=%b expected 1", ps); end
        button = 1'b1; ev[2] = 1'b1; abort_ok = 1;
        @(negedge clk);
        checks++;
        if ({mode, ps, snd, pend} !== 7'd0) begin failures++; $display("FAIL mute_on: mode=%b ps=%b snd=%b pend=%b expected all 0", mode, ps, snd, pend); end
        button = 1'b0; ev[1] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (ps !== 1'b0 || pend !== 4'b0000 || mode !== 1'b0) begin failures++; $display("FAIL mute_ignore: ps=%b pend=%b mode=%b expected 0,0000,0", ps, pend, mode); end
        ev = '0;
        @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        checks++;
        if (mode !== 1'b1 || pend !== 4'b0000) begin failures++; $display("FAIL mute_off: mode=%b pend=%b expected 1,0000", mode, pend); end
        button = 1'b0;
        ev[0] = 1'b1; q_exp.push_back(2'd0);
        @(negedge clk);
        @(negedge clk);
        ev[0] = 1'b0;
        drain("mute");
    endtask

    task automatic test_retrigger();
        bit saw;
        @(negedge clk);
        ev[0] = 1'b1; q_exp.push_back(2'd0); q_exp.push_back(2'd0);
        @(negedge clk);
        @(negedge clk);
        ev[0] = 1'b0;
        @(negedge clk);
        ev[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (pend !== 4'b0001 || ps !== 1'b1) begin failures++; $display("FAIL retrig_pend: pend=%b ps=%b expected 0001,1", pend, ps); end
        ev[0] = 1'b0;
        @(negedge clk);
        ev[0] = 1'b1;
        @(negedge clk);
        ev[0] = 1'b0;
        drain("retrig");
        saw = 0;
        repeat (30) begin @(negedge clk); if (ps === 1'b1) saw = 1; end
        checks++;
        if (saw) begin failures++; $display("FAIL retrig_extra: ps=1 seen expected no third burst"); end
    endtask

    task automatic test_held_reset();
        bit saw;
        @(negedge clk);
        ev[1] = 1'b1; q_exp.push_back(2'd1);
        repeat (4) @(negedge clk);
        checks++;
        if (ps !== 1'b1) begin failures++; $display("FAIL held_pre: ps=%b expected 1", ps); end
        ev[0] = 1'b1; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ps, snd, aid, pend} !== 8'd0 || mode !== 1'b1) begin failures++; $display("FAIL held_abort: ps=%b snd=%b aid=%0d pend=%b mode=%b expected 0,0,0,0000,1", ps, snd, aid, pend, mode); end
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (20) begin @(negedge clk); if (ps === 1'b1 || pend !== 4'b0000) saw = 1; end
        checks++;
        if (saw) begin failures++; $display("FAIL held_trigger: activity seen expected none for held inputs"); end
        ev = '0;
        @(negedge clk);
    endtask

    task automatic test_preempt();
        bit saw;
        @(negedge clk);
        ev[3] = 1'b1; q_exp.push_back(2'd3);
        @(negedge clk);
        @(negedge clk);
        ev[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ev[0] = 1'b1; q_exp.push_back(2'd0);
        @(negedge clk);
        checks++;
        if (pend !== 4'b0001 || aid !== 2'd3) begin failures++; $display("FAIL pre_pend: pend=%b aid=%0d expected 0001,3", pend, aid); end
        @(negedge clk);
`ifdef SOUND_PREEMPT_EN
        checks++;
        if (aid !== 2'd0 || ps !== 1'b1 || snd !== 1'b0 || pend !== 4'b0000) begin failures++; $display("FAIL pre_switch: aid=%0d ps=%b snd=%b pend=%b expected 0,1,0,0000", aid, ps, snd, pend); end
`else
        checks++;
        if (aid !== 2'd3 || ps !== 1'b1 || pend !== 4'b0001) begin failures++; $display("FAIL pre_wait: aid=%0d ps=%b pend=%b expected 3,1,0001", aid, ps, pend); end
`endif
        ev[0] = 1'b0;
        drain("pre");
        saw = 0;
        repeat (30) begin @(negedge clk); if (ps === 1'b1) saw = 1; end
        checks++;
        if (saw) begin failures++; $display("FAIL pre_resume: ps=1 seen expected idle"); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ev_b[1] = 1'b1; ev_b[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (pend_b !== 4'b0110 || ps_b !== 1'b0) begin failures++; $display("FAIL b2b_pend: pend=%b ps=%b expected 0110,0", pend_b, ps_b); end
        @(negedge clk);
        checks++;
        if (ps_b !== 1'b1 || aid_b !== 2'd1 || pend_b !== 4'b0100) begin failures++; $display("FAIL b2b_first: ps=%b aid=%0d pend=%b expected 1,1,0100", ps_b, aid_b, pend_b); end
        @(negedge clk);
        checks++;
        if (ps_b !== 1'b0) begin failures++; $display("FAIL b2b_idle: ps=%b expected 0", ps_b); end
        @(negedge clk);
        checks++;
        if (ps_b !== 1'b1 || aid_b !== 2'd2 || pend_b !== 4'b0000) begin failures++; $display("FAIL b2b_second: ps=%b aid=%0d pend=%b expected 1,2,0000", ps_b, aid_b, pend_b); end
        @(negedge clk);
        checks++;
        if (ps_b !== 1'b0 || snd_b !== 1'b0) begin failures++; $display("FAIL b2b_end: ps=%b snd=%b expected 0,0", ps_b, snd_b); end
        @(negedge clk);
        checks++;
        if (ps_b !== 1'b0) begin failures++; $display("FAIL b2b_stay: ps=%b expected 0", ps_b); end
        ev_b = '0;
    endtask

    initial begin
        rst = 1'b1; ev = '0; button = 1'b0; ev_b = '0; btn_b = 1'b0;
        test_reset();
        test_trigger();
        test_priority();
        test_mute();
        test_retrigger();
        test_held_reset();
        test_preempt();
        test_back_to_back();
        checks++;
        if (q_exp.size() != 0) begin failures++; $display("FAIL queue_end: %0d bursts outstanding expected 0", q_exp.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
